// File: rtl/moore_11011_nol_ch_sched_if.sv
// Channel-side handshake and detection-report bundle for the 11011 channel scheduler.
interface moore_11011_nol_ch_sched_if #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 2,
    parameter int unsigned CNTW = 16
);
    logic [NCH-1:0]  ch_valid;
    logic [NCH-1:0]  ch_bit;
    logic [NCH-1:0]  ch_ready;
    logic [NCH-1:0]  ch_clr;
    logic            det_valid;
    logic [CW-1:0]   det_ch;
    logic [NCH-1:0]  det_vec;
    logic [CNTW-1:0] det_cnt;
    logic            busy;

    modport master (
        output ch_valid, ch_bit, ch_clr,
        input  ch_ready, det_valid, det_ch, det_vec, det_cnt, busy
    );

    modport slave (
        input  ch_valid, ch_bit, ch_clr,
        output ch_ready, det_valid, det_ch, det_vec, det_cnt, busy
    );
endinterface

// File: rtl/moore_11011_nol_ch_sched.sv
// Round-robin time-shared non-overlapping 11011 Moore detector: one shared
// next-state core, per-channel saved context and one-entry holding buffer.
module moore_11011_nol_ch_sched #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    moore_11011_nol_ch_sched_if.slave    bus
);
    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101
    } state_t;

    state_t          ctx_q [NCH];
    state_t          ctx_d [NCH];
    logic [NCH-1:0]  hold_vld_q, hold_vld_d;
    logic [NCH-1:0]  hold_bit_q, hold_bit_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic            det_valid_q, det_valid_d;
    logic [CW-1:0]   det_ch_q, det_ch_d;
    logic [CNTW-1:0] det_cnt_q, det_cnt_d;

    logic [NCH-1:0]  ready;
    logic            gnt_found;
    logic [CW-1:0]   gnt;
    logic            gnt_take;
    state_t          gnt_next;

    // Illegal codes restart like S0.
    function automatic state_t next_state(input state_t s, input logic b);
        case (s)
            S0:      return b ? S1 : S0;
            S1:      return b ? S2 : S0;
            S2:      return b ? S2 : S3;
            S3:      return b ? S4 : S0;
            S4:      return b ? S5 : S0;
            S5:      return b ? S1 : S0;
            default: return b ? S1 : S0;
        endcase
    endfunction

    assign ready        = ~hold_vld_q & ~bus.ch_clr;
    assign bus.ch_ready = ready;

    // First held channel at or after ptr, wrapping past NCH-1.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt       = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_found && hold_vld_q[idx[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt       = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        ctx_d       = ctx_q;
        hold_vld_d  = hold_vld_q;
        hold_bit_d  = hold_bit_q;
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        det_cnt_d   = det_cnt_q;

        gnt_take = gnt_found & ~bus.ch_clr[gnt];
        gnt_next = next_state(ctx_q[gnt], hold_bit_q[gnt]);

        if (gnt_take) begin
            ctx_d[gnt]      = gnt_next;
            hold_vld_d[gnt] = 1'b0;
            ptr_d           = (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
            if (gnt_next == S5) begin
                det_valid_d = 1'b1;
                det_ch_d    = gnt;
                if (det_cnt_q != '1) det_cnt_d = det_cnt_q + 1'b1;
            end
        end

        // Accept never collides with a grant: a held channel is not ready.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.ch_valid[i] && ready[i]) begin
                hold_vld_d[i] = 1'b1;
                hold_bit_d[i] = bus.ch_bit[i];
            end
            if (bus.ch_clr[i]) begin
                ctx_d[i]      = S0;
                hold_vld_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) ctx_q[i] <= S0;
            hold_vld_q  <= '0;
            hold_bit_q  <= '0;
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_cnt_q   <= '0;
        end else begin
            ctx_q       <= ctx_d;
            hold_vld_q  <= hold_vld_d;
            hold_bit_q  <= hold_bit_d;
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_cnt_q   <= det_cnt_d;
        end
    end

    always_comb begin
        bus.det_vec = '0;
        for (int unsigned i = 0; i < NCH; i++) bus.det_vec[i] = (ctx_q[i] == S5);
    end

    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;
    assign bus.det_cnt   = det_cnt_q;
    assign bus.busy      = |hold_vld_q;
endmodule

// File: tb/tb_moore_11011_nol_ch_sched.sv
// Directed bench for the round-robin 11011 channel scheduler (CNTW=4 build).
module tb_moore_11011_nol_ch_sched;
    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned CNTW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    moore_11011_nol_ch_sched_if #(.NCH(NCH), .CW(CW), .CNTW(CNTW)) bus ();

    moore_11011_nol_ch_sched #(.NCH(NCH), .CW(CW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] bits;
        logic [3:0] clr;
        logic [3:0] ready;
        logic       dv;
        logic [1:0] dch;
        logic [3:0] vec;
        logic [3:0] cnt;
        logic       busy;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clr   = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_dv",    bus.det_valid, 0);
        chk("rst_dch",   bus.det_ch,    0);
        chk("rst_vec",   bus.det_vec,   0);
        chk("rst_cnt",   bus.det_cnt,   0);
        chk("rst_busy",  bus.busy,      0);
        chk("rst_ready", bus.ch_ready,  4'b1111);
        rst = 1'b0;
    endtask

    // One bit on one channel followed by an idle cycle; detection lands after the idle edge.
    task automatic send_bit(input int ch, input logic b, input logic exp_det, input string tag);
        logic [3:0] m;
        m = 4'(1 << ch);
        bus.ch_valid = m;
        bus.ch_bit   = b ? m : '0;
        #1;
        chk({tag, "_rdy"}, bus.ch_ready[ch], 1);
        tick();
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        chk({tag, "_busy"}, bus.busy, 1);
        tick();
        chk({tag, "_dv"}, bus.det_valid, exp_det);
        if (exp_det) chk({tag, "_dch"}, bus.det_ch, ch);
        chk({tag, "_vec"}, bus.det_vec[ch], exp_det);
    endtask

    // Bits and expected detections listed MSB-first.
    task automatic send_seq(input int ch, input int len, input logic [15:0] bits,
                            input logic [15:0] dets, input string tag);
        for (int k = len - 1; k >= 0; k--) send_bit(ch, bits[k], dets[k], tag);
    endtask

    initial begin
        int          n [4];
        logic [3:0]  v;
        logic [3:0]  b;
        logic [3:0]  exp_rdy;
        logic        exp_dv;
        int          exp_cnt;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clr   = '0;

        //            valid    bits     clr      ready    dv    dch   vec      cnt   busy
        tbl[0]  = '{4'b0001, 4'b0001, 4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b1};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0001, 4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b0};
        tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b0};
        tbl[6]  = '{4'b0001, 4'b0001, 4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b0};
        tbl[8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0000, 4'd0, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 1'b1, 2'd0, 4'b0001, 4'd1, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0001, 4'd1, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0001, 4'b1110, 1'b0, 2'd0, 4'b0000, 4'd1, 1'b0};
        tbl[12] = '{4'b0001, 4'b0001, 4'b0001, 4'b1110, 1'b0, 2'd0, 4'b0000, 4'd1, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, 4'b0000, 4'd1, 1'b0};

        // Channel 0 alone, 11011 with idle gaps, then flush behaviour.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            bus.ch_valid = tbl[k].valid;
            bus.ch_bit   = tbl[k].bits;
            bus.ch_clr   = tbl[k].clr;
            #1;
            chk("t1_ready", bus.ch_ready, tbl[k].ready);
            tick();
            chk("t1_dv", bus.det_valid, tbl[k].dv);
            if (tbl[k].dv) chk("t1_dch", bus.det_ch, tbl[k].dch);
            chk("t1_vec",  bus.det_vec, tbl[k].vec);
            chk("t1_cnt",  bus.det_cnt, tbl[k].cnt);
            chk("t1_busy", bus.busy,    tbl[k].busy);
        end
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clr   = '0;

        // Channel 2: no overlap credit after a detection.
        do_reset();
        send_seq(2, 10, 16'b1101111011, 16'b0000100001, "t2");
        chk("t2_cnt", bus.det_cnt, 2);

        // Channel 1: S2 absorbs extra ones.
        do_reset();
        send_seq(1, 6, 16'b111011, 16'b000001, "t3");
        chk("t3_cnt", bus.det_cnt, 1);

        // All channels streaming 11011 concurrently.
        do_reset();
        for (int i = 0; i < 4; i++) n[i] = 0;
        for (int c = 0; c < 22; c++) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = (n[i] < 5);
                b[i] = v[i] && (n[i] != 2);
            end
            bus.ch_valid = v;
            bus.ch_bit   = b;
            #1;
            if (c == 0)      exp_rdy = 4'b1111;
            else if (c == 1) exp_rdy = 4'b0000;
            else             exp_rdy = 4'(1 << ((c - 2) % 4));
            if (c <= 17) chk("t4_ready", bus.ch_ready, exp_rdy);
            for (int i = 0; i < 4; i++) if (v[i] && bus.ch_ready[i]) n[i]++;
            tick();
            exp_dv  = (c >= 17) && (c <= 20);
            exp_cnt = (c < 17) ? 0 : ((c >= 20) ? 4 : c - 16);
            chk("t4_dv", bus.det_valid, exp_dv);
            if (exp_dv) chk("t4_dch", bus.det_ch, c - 17);
            chk("t4_cnt", bus.det_cnt, exp_cnt);
        end
        bus.ch_valid = '0;
        bus.ch_bit   = '0;

        // Flush of channel 3 in its grant cycle; ptr must stay at 2.
        do_reset();
        send_seq(3, 4, 16'b1101, 16'b0000, "t5a");
        send_bit(1, 1'b1, 1'b0, "t5b");
        bus.ch_valid = 4'b1000;
        bus.ch_bit   = 4'b1000;
        tick();
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clr   = 4'b1000;
        #1;
        chk("t5_clr_ready", bus.ch_ready, 4'b0111);
        tick();
        bus.ch_clr = '0;
        chk("t5_clr_dv",   bus.det_valid, 0);
        chk("t5_clr_vec",  bus.det_vec,   0);
        chk("t5_clr_busy", bus.busy,      0);
        bus.ch_valid = 4'b0101;
        bus.ch_bit   = 4'b0000;
        tick();
        bus.ch_valid = '0;
        chk("t5_both_held", bus.ch_ready, 4'b1010);
        tick();
        chk("t5_ptr_kept", bus.ch_ready, 4'b1110);
        tick();
        chk("t5_idle_busy", bus.busy, 0);
        send_seq(3, 5, 16'b11011, 16'b00001, "t5c");
        chk("t5_cnt", bus.det_cnt, 1);

        // Counter saturation, then reset mid-pattern.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            send_seq(0, 5, 16'b11011, 16'b00001, "t6");
            chk("t6_sat_cnt", bus.det_cnt, (k > 15) ? 15 : k);
        end
        send_seq(0, 4, 16'b1101, 16'b0000, "t6p");
        bus.ch_valid = 4'b0001;
        bus.ch_bit   = 4'b0001;
        tick();
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        rst = 1'b1;
        tick();
        chk("t6_rst_dv",    bus.det_valid, 0);
        chk("t6_rst_vec",   bus.det_vec,   0);
        chk("t6_rst_cnt",   bus.det_cnt,   0);
        chk("t6_rst_busy",  bus.busy,      0);
        chk("t6_rst_ready", bus.ch_ready,  4'b1111);
        rst = 1'b0;
        send_bit(0, 1'b1, 1'b0, "t6r");
        chk("t6_post_cnt", bus.det_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
